t64_intctl: RTL and testbench

//  Vectored, nesting interrupt/exception controller for the t64 core.

---
 rtl/t64_int_pkg.sv | 40 ++++
 rtl/t64_prio_enc.sv | 29 ++
 rtl/t64_intctl.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_t64_intctl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t64_int_pkg.sv
// ----------------------------------------------------------------------------
// t64_int_pkg
// Shared types for the t64 vectored interrupt/exception controller.
//   cfg_sel_e     : configuration register select codes
//   stack_entry_t : one return-stack frame {pc, level, is_exc}
//   state_e       : controller sequencing states
//   EXC_NO_W      : width of the exception number
// ----------------------------------------------------------------------------
package t64_int_pkg;

    localparam int EXC_NO_W  = 8;
    // Frame field widths. The pc field covers the full 64-bit address space.
    // The level field holds values 0..NUM_IRQ, so 4 bits cover up to 15 lines.
    localparam int STK_PC_W  = 64;
    localparam int STK_LVL_W = 4;

    typedef enum logic [1:0] {
        CFG_MASK     = 2'd0,
        CFG_INT_BASE = 2'd1,
        CFG_EXC_BASE = 2'd2,
        CFG_ENABLES  = 2'd3
    } cfg_sel_e;

    // pc    : address to resume at after the handler returns
    // level : priority level that was active before this handler was entered
    // is_exc: 1 when this frame belongs to an exception handler
    typedef struct packed {
        logic [STK_PC_W-1:0]  pc;
        logic [STK_LVL_W-1:0] level;
        logic                 is_exc;
    } stack_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TAKE      = 2'd1,
        ST_RET       = 2'd2,
        ST_UNHANDLED = 2'd3
    } state_e;

endpackage

// File: rtl/t64_prio_enc.sv
// ----------------------------------------------------------------------------
// t64_prio_enc
// Find-first-set priority encoder; the lowest set bit wins.
//   req   in  WIDTH  request vector
//   valid out 1      at least one request bit set
//   index out IDX_W  index of the lowest set bit (0 when none)
// ----------------------------------------------------------------------------
module t64_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/t64_intctl.sv
// ----------------------------------------------------------------------------
// t64_intctl
// Vectored, nesting interrupt/exception controller for the t64 core.
// Prioritised interrupt lines with per-line vectors, a latched exception
// request, and a return stack holding the interrupted context.
//
// Ports
//   clk         in   1        clock
//   reset       in   1        synchronous, active-high
//   irq         in   NUM_IRQ  interrupt requests (index 0 = highest priority)
//   cfg_we      in   1        config write strobe
//   cfg_sel     in   2        0=mask 1=int base 2=exc base 3=enables
//   cfg_wdata   in   XLEN     config data
//   except_req  in   1        exception pulse
//   except_no   in   8        exception number, sampled with except_req
//   boundary    in   1        core at a fetch boundary, redirect allowed
//   cur_pc      in   XLEN     return address captured on a take
//   iret        in   1        return-from-handler pulse
//   take        out  1        one-cycle redirect pulse
//   take_addr   out  XLEN     vector target, valid while take=1
//   intack      out  NUM_IRQ  one-hot acknowledge, pulses with take for irqs
//   ret_valid   out  1        one-cycle pulse, ret_addr valid
//   ret_addr    out  XLEN     popped return address
//   unhandled   out  1        sticky double-fault / overflow indication
// ----------------------------------------------------------------------------
module t64_intctl
    import t64_int_pkg::*;
#(
    parameter int                 NUM_IRQ    = 8,
    parameter int                 XLEN       = 64,
    parameter int                 NEST_DEPTH = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_sel,
    input  logic [XLEN-1:0]     cfg_wdata,
    input  logic                except_req,
    input  logic [EXC_NO_W-1:0] except_no,
    input  logic                boundary,
    input  logic [XLEN-1:0]     cur_pc,
    input  logic                iret,
    output logic                take,
    output logic [XLEN-1:0]     take_addr,
    output logic [NUM_IRQ-1:0]  intack,
    output logic                ret_valid,
    output logic [XLEN-1:0]     ret_addr,
    output logic                unhandled
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int LVL_W = $clog2(NUM_IRQ + 1);
    localparam int PTR_W = $clog2(NEST_DEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0]  mask_reg;
    logic [XLEN-1:0]     int_base_reg;
    logic [XLEN-1:0]     exc_base_reg;
    logic                int_en_reg;
    logic                exc_en_reg;

    logic [NUM_IRQ-1:0]  irq_prev_reg;
    logic [NUM_IRQ-1:0]  edge_pend_reg;
    logic [NUM_IRQ-1:0]  edge_pend_next;

    logic                exc_pend_reg;
    logic [EXC_NO_W-1:0] exc_no_reg;

    state_e              state_reg;
    state_e              state_next;
    logic [LVL_W-1:0]    cur_level_reg;
    logic [LVL_W-1:0]    cur_level_next;
    logic [PTR_W-1:0]    ptr_reg;
    stack_entry_t        stack_reg [NEST_DEPTH];

    logic [XLEN-1:0]     take_addr_reg;
    logic [XLEN-1:0]     take_addr_next;
    logic [NUM_IRQ-1:0]  intack_reg;
    logic [NUM_IRQ-1:0]  intack_next;
    logic [XLEN-1:0]     ret_addr_reg;
    logic [XLEN-1:0]     ret_addr_next;

    // ------------------------------------------------------------------
    // Pending interrupts
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0]  pend_vec;
    logic                pend_valid;
    logic [IDX_W-1:0]    pend_idx;
    logic                take_irq;
    logic                take_exc;
    logic                do_push;
    logic                do_pop;
    stack_entry_t        push_entry;
    stack_entry_t        top_entry;

    // Edge lines latch a rising edge; a cleared mask or a take drops it.
    // Level lines follow the live request gated by the mask.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
        assign edge_pend_next[gi] = EDGE_MASK[gi]
                                  & (edge_pend_reg[gi] | (irq[gi] & ~irq_prev_reg[gi]))
                                  & mask_reg[gi]
                                  & ~(take_irq && (pend_idx == IDX_W'(gi)));
        assign pend_vec[gi] = EDGE_MASK[gi] ? edge_pend_reg[gi]
                                            : (irq[gi] & mask_reg[gi]);
    end

    t64_prio_enc #(
        .WIDTH (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (pend_vec),
        .valid (pend_valid),
        .index (pend_idx)
    );

    // An exception request arriving on the decision edge itself competes
    // immediately, so it beats an interrupt presented at the same boundary.
    logic                exc_active;
    logic [EXC_NO_W-1:0] exc_no_cur;
    assign exc_active = exc_pend_reg | except_req;
    assign exc_no_cur = exc_pend_reg ? exc_no_reg : except_no;

    // ------------------------------------------------------------------
    // Return stack helpers
    // ------------------------------------------------------------------
    logic                  stack_full;
    logic                  stack_empty;
    logic                  in_exc;
    logic [NEST_DEPTH-1:0] push_sel;

    assign stack_full  = (ptr_reg == PTR_W'(NEST_DEPTH));
    assign stack_empty = (ptr_reg == '0);

    always_comb begin
        top_entry = '0;
        for (int k = 0; k < NEST_DEPTH; k++) begin
            if (ptr_reg == PTR_W'(k + 1)) begin
                top_entry = stack_reg[k];
            end
        end
    end

    // The innermost frame tells whether an exception handler is running.
    assign in_exc = !stack_empty && top_entry.is_exc;

    for (genvar gi = 0; gi < NEST_DEPTH; gi++) begin : g_push_sel
        assign push_sel[gi] = do_push && (ptr_reg == PTR_W'(gi));
    end

    // ------------------------------------------------------------------
    // Decision / next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cur_level_next = cur_level_reg;
        take_addr_next = take_addr_reg;
        ret_addr_next  = ret_addr_reg;
        intack_next    = '0;
        take_irq       = 1'b0;
        take_exc       = 1'b0;
        do_push        = 1'b0;
        do_pop         = 1'b0;
        push_entry     = '0;

        unique case (state_reg)
            ST_IDLE: begin
                if (iret) begin
                    // iret always suppresses a take in the same cycle.
                    if (!stack_empty) begin
                        do_pop         = 1'b1;
                        cur_level_next = LVL_W'(top_entry.level);
                        ret_addr_next  = XLEN'(top_entry.pc);
                        state_next     = ST_RET;
                    end
                end else if (boundary) begin
                    if (exc_active) begin
                        if (exc_en_reg && !in_exc && !stack_full) begin
                            take_exc          = 1'b1;
                            do_push           = 1'b1;
                            push_entry.pc     = STK_PC_W'(cur_pc);
                            push_entry.level  = STK_LVL_W'(cur_level_reg);
                            push_entry.is_exc = 1'b1;
                            take_addr_next    = exc_base_reg + XLEN'({exc_no_cur, 3'b000});
                            state_next        = ST_TAKE;
                        end else begin
                            state_next = ST_UNHANDLED;
                        end
                    end else if (pend_valid && int_en_reg && !stack_full
                                 && (LVL_W'(pend_idx) < cur_level_reg)) begin
                        take_irq          = 1'b1;
                        do_push           = 1'b1;
                        push_entry.pc     = STK_PC_W'(cur_pc);
                        push_entry.level  = STK_LVL_W'(cur_level_reg);
                        push_entry.is_exc = 1'b0;
                        cur_level_next    = LVL_W'(pend_idx);
                        take_addr_next    = int_base_reg + XLEN'({pend_idx, 3'b000});
                        intack_next       = NUM_IRQ'(1) << pend_idx;
                        state_next        = ST_TAKE;
                    end
                end
            end
            ST_TAKE, ST_RET: begin
                state_next = ST_IDLE;
            end
            ST_UNHANDLED: begin
                state_next = ST_UNHANDLED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cur_level_reg <= LVL_W'(NUM_IRQ);
            ptr_reg       <= '0;
            take_addr_reg <= '0;
            intack_reg    <= '0;
            ret_addr_reg  <= '0;
            exc_pend_reg  <= 1'b0;
            exc_no_reg    <= '0;
            irq_prev_reg  <= '0;
            edge_pend_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cur_level_reg <= cur_level_next;
            take_addr_reg <= take_addr_next;
            intack_reg    <= intack_next;
            ret_addr_reg  <= ret_addr_next;
            irq_prev_reg  <= irq;
            edge_pend_reg <= edge_pend_next;

            if (do_push) begin
                ptr_reg <= ptr_reg + PTR_W'(1);
            end else if (do_pop) begin
                ptr_reg <= ptr_reg - PTR_W'(1);
            end

            // Taking a latched exception frees the slot for a request that
            // arrives on that same edge; otherwise the first request wins.
            if (take_exc) begin
                exc_pend_reg <= exc_pend_reg & except_req;
            end else begin
                exc_pend_reg <= exc_pend_reg | except_req;
            end
            if (except_req && (take_exc || !exc_pend_reg)) begin
                exc_no_reg <= except_no;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NEST_DEPTH; k++) begin
                stack_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NEST_DEPTH; k++) begin
                if (push_sel[k]) begin
                    stack_reg[k] <= push_entry;
                end
            end
        end
    end

    // Configuration; vector bases are 8-byte aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_reg     <= '0;
            int_base_reg <= '0;
            exc_base_reg <= '0;
            int_en_reg   <= 1'b0;
            exc_en_reg   <= 1'b0;
        end else if (cfg_we) begin
            unique case (cfg_sel_e'(cfg_sel))
                CFG_MASK:     mask_reg     <= cfg_wdata[NUM_IRQ-1:0];
                CFG_INT_BASE: int_base_reg <= {cfg_wdata[XLEN-1:3], 3'b000};
                CFG_EXC_BASE: exc_base_reg <= {cfg_wdata[XLEN-1:3], 3'b000};
                CFG_ENABLES: begin
                    int_en_reg <= cfg_wdata[0];
                    exc_en_reg <= cfg_wdata[1];
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign take      = (state_reg == ST_TAKE);
    assign take_addr = take_addr_reg;
    assign intack    = intack_reg;
    assign ret_valid = (state_reg == ST_RET);
    assign ret_addr  = ret_addr_reg;
    assign unhandled = (state_reg == ST_UNHANDLED);

endmodule

// File: tb/tb_t64_intctl.sv
// ----------------------------------------------------------------------------
// tb_t64_intctl
// Two controller instances share one stimulus stream:
//   dut_a : NEST_DEPTH=4, all lines level-sensitive
//   dut_b : NEST_DEPTH=2, line 4 edge-latched
// ----------------------------------------------------------------------------
module tb_t64_intctl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [63:0] cfg_wdata;
    logic        except_req;
    logic [7:0]  except_no;
    logic        boundary;
    logic [63:0] cur_pc;
    logic        iret;

    logic        a_take, a_ret_valid, a_unhandled;
    logic [63:0] a_take_addr, a_ret_addr;
    logic [7:0]  a_intack;
    logic        b_take, b_ret_valid, b_unhandled;
    logic [63:0] b_take_addr, b_ret_addr;
    logic [7:0]  b_intack;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    t64_intctl #(.NUM_IRQ(8), .XLEN(64), .NEST_DEPTH(4), .EDGE_MASK(8'h00)) dut_a (
        .clk(clk), .reset(reset), .irq(irq), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_wdata(cfg_wdata), .except_req(except_req), .except_no(except_no),
        .boundary(boundary), .cur_pc(cur_pc), .iret(iret),
        .take(a_take), .take_addr(a_take_addr), .intack(a_intack),
        .ret_valid(a_ret_valid), .ret_addr(a_ret_addr), .unhandled(a_unhandled)
    );

    t64_intctl #(.NUM_IRQ(8), .XLEN(64), .NEST_DEPTH(2), .EDGE_MASK(8'h10)) dut_b (
        .clk(clk), .reset(reset), .irq(irq), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_wdata(cfg_wdata), .except_req(except_req), .except_no(except_no),
        .boundary(boundary), .cur_pc(cur_pc), .iret(iret),
        .take(b_take), .take_addr(b_take_addr), .intack(b_intack),
        .ret_valid(b_ret_valid), .ret_addr(b_ret_addr), .unhandled(b_unhandled)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [7:0] i_irq, input logic bnd, input logic ir,
                       input logic exr, input logic [7:0] eno, input logic [63:0] pc);
        irq = i_irq; boundary = bnd; iret = ir;
        except_req = exr; except_no = eno; cur_pc = pc;
        step();
        boundary = 1'b0; iret = 1'b0; except_req = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [63:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic setup();
        reset = 1'b1;
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
        reset = 1'b0;
        cfg_write(2'd0, 64'hFF);
        cfg_write(2'd1, 64'h1000);
        cfg_write(2'd2, 64'h2000);
        cfg_write(2'd3, 64'h3);
    endtask

    typedef struct {
        logic [7:0]  irq;
        logic        exr;
        logic [7:0]  eno;
        logic        exp_take;
        logic [63:0] exp_addr;
        logic [7:0]  exp_ack;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        int          level;
    } frame_t;

    vec_t   vecs[8];
    frame_t mstk[$];
    frame_t fr;
    int     mlevel;
    int     first;
    logic [7:0]  pat;
    logic [63:0] pc;
    logic        is_iret, exp_take, exp_ret;
    logic [63:0] exp_addr, exp_raddr;
    logic [7:0]  exp_ack;

    initial begin
        reset = 1'b1; irq = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0;
        except_req = 1'b0; except_no = '0; boundary = 1'b0; cur_pc = '0; iret = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_take", {63'b0, a_take}, 64'h0);
        check("rst_ret_valid", {63'b0, a_ret_valid}, 64'h0);
        check("rst_unhandled", {63'b0, a_unhandled}, 64'h0);

        // ---------------- single-decision vectors ----------------
        vecs[0] = '{8'h08, 1'b0, 8'h00, 1'b1, 64'h1018, 8'h08};
        vecs[1] = '{8'h80, 1'b0, 8'h00, 1'b1, 64'h1038, 8'h80};
        vecs[2] = '{8'h01, 1'b0, 8'h00, 1'b1, 64'h1000, 8'h01};
        vecs[3] = '{8'h0A, 1'b0, 8'h00, 1'b1, 64'h1008, 8'h02};
        vecs[4] = '{8'h00, 1'b0, 8'h00, 1'b0, 64'h0000, 8'h00};
        vecs[5] = '{8'h01, 1'b1, 8'h02, 1'b1, 64'h2010, 8'h00};
        vecs[6] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 64'h27F8, 8'h00};
        vecs[7] = '{8'hE0, 1'b0, 8'h00, 1'b1, 64'h1028, 8'h20};
        for (int v = 0; v < 8; v++) begin
            setup();
            cyc(vecs[v].irq, 1'b1, 1'b0, vecs[v].exr, vecs[v].eno, 64'h400);
            $display("vec %0d irq=%02h exc=%0d take=%0d addr=%0h ack=%02h",
                     v, vecs[v].irq, vecs[v].exr, a_take, a_take_addr, a_intack);
            check("vec_take", {63'b0, a_take}, {63'b0, vecs[v].exp_take});
            check("vec_addr", a_take_addr, vecs[v].exp_addr);
            check("vec_ack", {56'b0, a_intack}, {56'b0, vecs[v].exp_ack});
        end

        // ---------------- nesting and return ----------------
        setup();
        cyc(8'h08, 1'b1, 1'b0, 1'b0, 8'h0, 64'h100);
        check("nest_irq3_addr", a_take_addr, 64'h1018);
        cyc(8'h08, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h28, 1'b1, 1'b0, 1'b0, 8'h0, 64'h200);
        check("nest_irq5_held", {63'b0, a_take}, 64'h0);
        cyc(8'h2A, 1'b1, 1'b0, 1'b0, 8'h0, 64'h300);
        check("nest_irq1_take", {63'b0, a_take}, 64'h1);
        check("nest_irq1_addr", a_take_addr, 64'h1008);
        cyc(8'h2A, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h28, 1'b0, 1'b1, 1'b0, 8'h0, 64'h0);
        check("nest_ret1_valid", {63'b0, a_ret_valid}, 64'h1);
        check("nest_ret1_addr", a_ret_addr, 64'h300);
        cyc(8'h28, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h20, 1'b0, 1'b1, 1'b0, 8'h0, 64'h0);
        check("nest_ret2_addr", a_ret_addr, 64'h100);
        cyc(8'h20, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h20, 1'b1, 1'b0, 1'b0, 8'h0, 64'h500);
        check("nest_irq5_late", a_take_addr, 64'h1028);
        check("nest_irq5_ack", {56'b0, a_intack}, 64'h20);

        // ---------------- exception then double fault ----------------
        setup();
        cyc(8'h01, 1'b1, 1'b0, 1'b1, 8'h02, 64'h600);
        check("exc_addr", a_take_addr, 64'h2010);
        check("exc_no_ack", {56'b0, a_intack}, 64'h0);
        cyc(8'h01, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 64'h0);
        cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h0, 64'h700);
        check("dbl_unhandled", {63'b0, a_unhandled}, 64'h1);
        check("dbl_no_take", {63'b0, a_take}, 64'h0);
        cyc(8'h01, 1'b1, 1'b0, 1'b0, 8'h0, 64'h800);
        check("dbl_sticky", {63'b0, a_unhandled}, 64'h1);
        check("dbl_blocks_take", {63'b0, a_take}, 64'h0);

        // ---------------- full stack on the depth-2 instance ----------------
        setup();
        cyc(8'h08, 1'b1, 1'b0, 1'b0, 8'h0, 64'hA00);
        check("full_take3", b_take_addr, 64'h1018);
        cyc(8'h08, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h0C, 1'b1, 1'b0, 1'b0, 8'h0, 64'hB00);
        check("full_take2", b_take_addr, 64'h1010);
        cyc(8'h0C, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h0E, 1'b1, 1'b0, 1'b0, 8'h0, 64'hC00);
        check("full_irq1_pending", {63'b0, b_take}, 64'h0);
        check("deep_irq1_taken", {63'b0, a_take}, 64'h1);
        cyc(8'h0E, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        // iret together with boundary: return wins, no take
        cyc(8'h0E, 1'b1, 1'b1, 1'b0, 8'h0, 64'hD00);
        check("full_iret_ret", {63'b0, b_ret_valid}, 64'h1);
        check("full_iret_addr", b_ret_addr, 64'hB00);
        check("full_iret_no_take", {63'b0, b_take}, 64'h0);
        cyc(8'h0E, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h0E, 1'b1, 1'b0, 1'b0, 8'h0, 64'hE00);
        check("full_irq1_late", b_take_addr, 64'h1008);
        check("full_irq1_ack", {56'b0, b_intack}, 64'h02);

        // ---------------- edge-latched line 4 ----------------
        setup();
        cfg_write(2'd0, 64'hEF);
        cyc(8'h10, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cfg_write(2'd0, 64'hFF);
        cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h0, 64'h0);
        check("edge_masked_dropped", {63'b0, b_take}, 64'h0);
        cyc(8'h10, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h0, 64'hF00);
        check("edge_take", {63'b0, b_take}, 64'h1);
        check("edge_addr", b_take_addr, 64'h1020);
        check("edge_ack", {56'b0, b_intack}, 64'h10);
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h0, 64'h0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h0, 64'h0);
        check("edge_once", {63'b0, b_take}, 64'h0);

        // ---------------- reset mid-nest ----------------
        setup();
        cyc(8'h08, 1'b1, 1'b0, 1'b0, 8'h0, 64'h1100);
        cyc(8'h08, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        cyc(8'h0A, 1'b1, 1'b0, 1'b0, 8'h0, 64'h1200);
        reset = 1'b1;
        cyc(8'h0A, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        check("mrst_take", {63'b0, a_take}, 64'h0);
        check("mrst_take_addr", a_take_addr, 64'h0);
        check("mrst_intack", {56'b0, a_intack}, 64'h0);
        check("mrst_ret_addr", a_ret_addr, 64'h0);
        check("mrst_unhandled", {63'b0, a_unhandled}, 64'h0);
        reset = 1'b0;
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h0, 64'h0);
        check("mrst_iret_empty", {63'b0, a_ret_valid}, 64'h0);
        cyc(8'h08, 1'b1, 1'b0, 1'b0, 8'h0, 64'h1300);
        check("mrst_masks_cleared", {63'b0, a_take}, 64'h0);

        // ---------------- randomized nesting against a stack model ----------------
        setup();
        mstk.delete();
        mlevel = 8;
        for (int op = 0; op < 80; op++) begin
            is_iret = ($urandom_range(0, 2) == 0);
            pat = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            pc = {$urandom, $urandom};
            exp_take = 1'b0; exp_ret = 1'b0; exp_addr = 64'h0; exp_raddr = 64'h0; exp_ack = 8'h0;
            if (is_iret) begin
                if (mstk.size() > 0) begin
                    fr = mstk.pop_back();
                    exp_ret = 1'b1;
                    exp_raddr = fr.pc;
                    mlevel = fr.level;
                end
            end else begin
                first = -1;
                for (int i = 0; i < 8; i++) begin
                    if (pat[i]) begin
                        first = i;
                        break;
                    end
                end
                if (first >= 0 && first < mlevel && mstk.size() < 4) begin
                    exp_take = 1'b1;
                    exp_addr = 64'h1000 + 64'(first) * 8;
                    exp_ack = 8'(1 << first);
                    mstk.push_back('{pc, mlevel});
                    mlevel = first;
                end
            end
            cyc(is_iret ? 8'h00 : pat, !is_iret, is_iret, 1'b0, 8'h0, pc);
            $display("op %0d %s pat=%02h take=%0d addr=%0h ret=%0d raddr=%0h depth=%0d",
                     op, is_iret ? "iret" : "bnd", pat, a_take, a_take_addr,
                     a_ret_valid, a_ret_addr, mstk.size());
            check("rnd_take", {63'b0, a_take}, {63'b0, exp_take});
            check("rnd_ack", {56'b0, a_intack}, {56'b0, exp_ack});
            check("rnd_ret", {63'b0, a_ret_valid}, {63'b0, exp_ret});
            if (exp_take) check("rnd_addr", a_take_addr, exp_addr);
            if (exp_ret)  check("rnd_raddr", a_ret_addr, exp_raddr);
            cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
